// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package mp_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Word index width; a single-word operand still needs a 1-bit index.
    function automatic int idx_width(input int k);
        return (k <= 2) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/n_bit_pg_carry_ripple.sv
// N-bit ripple-carry adder built from per-bit generate/propagate terms.
module n_bit_pg_carry_ripple #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N-1:0] p;
    logic [N-1:0] g;
    logic [N:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < N; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s    = p ^ c[N-1:0];
    assign cout = c[N];

endmodule

// File: rtl/mp_add_sequencer.sv
// K*N-bit add/subtract computed one N-bit word per clock, LS word first,
// through a single shared ripple-carry adder.
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int N = 32,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*K-1:0] op_a,
    input  logic [N*K-1:0] op_b,
    input  logic           sub,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*K-1:0] result,
    output logic           carry_out,
    output logic           overflow
);

    localparam int W  = N * K;
    localparam int IW = idx_width(K);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // ready/valid come from registered state only, gated by rst_n.
    state_t        state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          sub_reg;
    logic          carry_reg;

    logic [N-1:0]  word_b;
    logic [N-1:0]  add_a;
    logic [N-1:0]  add_b;
    logic          add_cin;
    logic [N-1:0]  add_s;
    logic          add_cout;
    logic          last_word;

    always_comb begin
        add_a   = a_reg[idx*N +: N];
        word_b  = b_reg[idx*N +: N];
        add_b   = sub_reg ? ~word_b : word_b;
        add_cin = (idx == '0) ? sub_reg : carry_reg;
    end

    assign last_word = (idx == IW'(K - 1));

    n_bit_pg_carry_ripple #(.N(N)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= op_a;
                        b_reg   <= op_b;
                        sub_reg <= sub;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    result[idx*N +: N] <= add_s;
                    carry_reg          <= add_cout;
                    if (last_word) begin
                        carry_out <= add_cout;
                        // Sign check uses the effective (possibly inverted) B word.
                        overflow  <= (add_a[N-1] == add_b[N-1]) && (add_s[N-1] != add_a[N-1]);
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = rst_n && (state == DONE);

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench for mp_add_sequencer with an expected-result queue.
module tb_mp_add_sequencer;

    localparam int N = 32;
    localparam int K = 4;
    localparam int W = N * K;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         sub = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int checks = 0;
    int failures = 0;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] held;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    always #5 clk = ~clk;

    mp_add_sequencer #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W+1:0] obs, input logic [W+1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] v;
        for (int i = 0; i < K; i++) v[i*N +: N] = $urandom();
        return v;
    endfunction

    // Whole-width reference: {overflow, carry_out, result}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] bb;
        logic [W:0]   t;
        logic         ov;
        bb = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
        ov = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
        return {ov, t[W], t[W-1:0]};
    endfunction

    // Drives one operation and returns just after the accepting edge.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_ready", {{(W+1){1'b0}}, in_ready}, 1);
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        sub = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = rnd_word();
        op_b = rnd_word();
        sub = ~s;
    endtask

    // Waits for out_valid, checks latency and the popped expectation,
    // then optionally checks the output handshake completed.
    task automatic collect(input string tag, input bit do_hs, output logic [W+1:0] exp_out);
        int lat;
        lat = 0;
        exp_out = '0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid === 1'b1) break;
        end
        chk({tag, "_latency"}, (W+2)'(lat), (W+2)'(K));
        chk({tag, "_in_ready_low"}, {{(W+1){1'b0}}, in_ready}, 0);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_nonempty"}, 0, 1);
        end else begin
            exp_out = exp_q.pop_front();
            chk(tag, {overflow, carry_out, result}, exp_out);
        end
        if (do_hs) begin
            @(posedge clk);
            #1;
            chk({tag, "_hs_out_valid"}, {{(W+1){1'b0}}, out_valid}, 0);
            chk({tag, "_hs_in_ready"}, {{(W+1){1'b0}}, in_ready}, 1);
        end
    endtask

    initial begin
        // Reset behaviour
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {{(W+1){1'b0}}, in_ready}, 0);
        chk("rst_out_valid", {{(W+1){1'b0}}, out_valid}, 0);
        chk("rst_outputs", {overflow, carry_out, result}, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {{(W+1){1'b0}}, in_ready}, 1);

        // Wrap-around
        exp_q.push_back({1'b0, 1'b1, {W{1'b0}}});
        accept({W{1'b1}}, 1, 1'b0);
        collect("wrap", 1'b1, held);

        // Inter-word carry, accepted back to back at EK+2
        exp_q.push_back({2'b00, 128'h0000_0000_0000_0000_0000_0001_0000_0000});
        accept(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 1, 1'b0);
        collect("interword", 1'b1, held);

        // Subtraction with borrow
        exp_q.push_back({2'b00, {{(W-4){1'b1}}, 4'hE}});
        accept(5, 7, 1'b1);
        collect("sub_borrow", 1'b1, held);

        // Signed overflow, add and sub
        exp_q.push_back({2'b10, 1'b1, {(W-1){1'b0}}});
        accept({1'b0, {(W-1){1'b1}}}, 1, 1'b0);
        collect("ovf_add", 1'b1, held);
        exp_q.push_back({2'b11, 1'b0, {(W-1){1'b1}}});
        accept({1'b1, {(W-1){1'b0}}}, 1, 1'b1);
        collect("ovf_sub", 1'b1, held);

        // Random operations
        for (int i = 0; i < 4; i++) begin
            ra = rnd_word();
            rb = rnd_word();
            rs = 1'($urandom_range(0, 1));
            exp_q.push_back(model(ra, rb, rs));
            accept(ra, rb, rs);
            collect("random", 1'b1, held);
        end

        // Backpressure with in_valid toggling new operands
        out_ready = 1'b0;
        ra = rnd_word();
        rb = rnd_word();
        exp_q.push_back(model(ra, rb, 1'b0));
        accept(ra, rb, 1'b0);
        collect("bp_first", 1'b0, held);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            op_a = rnd_word();
            op_b = rnd_word();
            sub = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("bp_out_valid", {{(W+1){1'b0}}, out_valid}, 1);
            chk("bp_in_ready", {{(W+1){1'b0}}, in_ready}, 0);
            chk("bp_hold", {overflow, carry_out, result}, held);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", {{(W+1){1'b0}}, out_valid}, 0);
        chk("bp_release_in_ready", {{(W+1){1'b0}}, in_ready}, 1);
        exp_q.push_back(model(128'h1234, 128'h5678, 1'b0));
        accept(128'h1234, 128'h5678, 1'b0);
        collect("bp_next", 1'b1, held);

        // Reset while idx == 2
        accept(rnd_word(), rnd_word(), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready", {{(W+1){1'b0}}, in_ready}, 1);
        chk("abort_outputs", {overflow, carry_out, result}, 0);
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_valid", {{(W+1){1'b0}}, out_valid}, 0);
            @(posedge clk);
            #1;
        end
        exp_q.push_back({2'b00, 128'd7});
        accept(3, 4, 1'b0);
        collect("after_abort", 1'b1, held);

        chk("queue_empty", (W+2)'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
